pio_rw_sequencer: RTL and testbench

- Avalon-MM master that owns the 32-bit bidirectional PIO slave (address 0 = data, address 1 = direction, registered readdata).
- Turns single-word read/write commands from one FPGA-side requester into the correct ordered direction and data register accesses, with bus-turnaround waits.
- Keeps a shadow copy of the direction register so it only rewrites direction when the bus mode actually changes.
- Sits between the requester (for example, the command decoder) and the PIO in the soc_system fabric.

---
 rtl/pio_rw_seq_pkg.sv | 30 +++
 rtl/pio_rw_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pio_rw_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_rw_seq_pkg.sv
// rtl/pio_rw_seq_pkg.sv - shared states, PIO register map and direction patterns for pio_rw_sequencer
// Optional feature macro: PIO_RW_SEQ_DIR_VERIFY_EN
package pio_rw_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DATA_WR,
        S_DIR_WR,
        S_TURN,
        S_RD_ADDR,
        S_RD_CAP,
        S_RSP
`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
        ,
        S_VFY_ADDR,
        S_VFY_CAP
`endif
    } seq_state_e;

    typedef enum logic {
        DIR_MODE_IN  = 1'b0,
        DIR_MODE_OUT = 1'b1
    } dir_mode_e;

    localparam logic [1:0]  PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0]  PIO_ADDR_DIR  = 2'd1;
    localparam logic [31:0] DIR_ALL_OUT   = 32'hFFFF_FFFF;
    localparam logic [31:0] DIR_ALL_IN    = 32'h0000_0000;

endpackage

// File: rtl/pio_rw_sequencer.sv
// rtl/pio_rw_sequencer.sv - Avalon-MM master turning word commands into ordered PIO direction/data accesses
// Optional feature macro: PIO_RW_SEQ_DIR_VERIFY_EN (direction readback check, drives dir_err)
module pio_rw_sequencer
    import pio_rw_seq_pkg::*;
#(
    parameter int TURN_CYCLES = 2,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic          dir_err,
    output logic [1:0]    avm_address,
    output logic          avm_chipselect,
    output logic          avm_write_n,
    output logic [DW-1:0] avm_writedata,
    input  logic [DW-1:0] avm_readdata
);

    localparam logic [3:0] TURN_LAST = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    seq_state_e    r_state;
    seq_state_e    w_next_state;
    seq_state_e    w_follow;
    seq_state_e    w_post_dir;
    dir_mode_e     r_dir_mode;
    logic          r_live;
    logic          r_write;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rsp_rdata;
    logic [3:0]    r_turn_cnt;
    logic [DW-1:0] w_dir_pattern;
    logic          w_accept;

    // The direction pattern is always the one for the mode the current command needs.
    assign w_dir_pattern = r_write ? {DW{DIR_ALL_OUT[0]}} : {DW{DIR_ALL_IN[0]}};
    assign w_follow      = r_write ? S_RSP : S_RD_ADDR;
`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
    assign w_post_dir    = S_VFY_ADDR;
`else
    assign w_post_dir    = w_follow;
`endif

    assign cmd_ready = (r_state == S_IDLE) && r_live;
    assign w_accept  = cmd_valid && cmd_ready;
    assign rsp_valid = (r_state == S_RSP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_rdata = r_rsp_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        avm_address    = PIO_ADDR_DATA;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_write) begin
                        w_next_state = S_DATA_WR;
                    end else if (r_dir_mode != DIR_MODE_IN) begin
                        w_next_state = S_DIR_WR;
                    end else begin
                        w_next_state = S_RD_ADDR;
                    end
                end
            end
            // Data lands before direction flips so the pins never drive stale data.
            S_DATA_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = r_wdata;
                w_next_state   = (r_dir_mode != DIR_MODE_OUT) ? S_DIR_WR : S_RSP;
            end
            S_DIR_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_ADDR_DIR;
                avm_writedata  = w_dir_pattern;
                w_next_state   = (TURN_CYCLES > 0) ? S_TURN : w_post_dir;
            end
            S_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    w_next_state = w_post_dir;
                end
            end
            S_RD_ADDR: begin
                avm_chipselect = 1'b1;
                w_next_state   = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_next_state = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
            S_VFY_ADDR: begin
                avm_chipselect = 1'b1;
                avm_address    = PIO_ADDR_DIR;
                w_next_state   = S_VFY_CAP;
            end
            S_VFY_CAP: begin
                avm_address  = PIO_ADDR_DIR;
                w_next_state = w_follow;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live      <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_dir_mode  <= DIR_MODE_IN;
            r_turn_cnt  <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= cmd_write;
                        r_wdata     <= cmd_wdata;
                        r_rsp_rdata <= '0;
                    end
                end
                S_DIR_WR: begin
                    r_dir_mode <= r_write ? DIR_MODE_OUT : DIR_MODE_IN;
                    r_turn_cnt <= '0;
                end
                S_TURN:   r_turn_cnt  <= r_turn_cnt + 4'd1;
                S_RD_CAP: r_rsp_rdata <= avm_readdata;
                default: ;
            endcase
        end
    end

`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
    logic r_dir_err;

    // Sticky until reset: a direction register that reads back wrong is a board-level fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir_err <= 1'b0;
        end else if (r_state == S_VFY_CAP && avm_readdata != w_dir_pattern) begin
            r_dir_err <= 1'b1;
        end
    end

    assign dir_err = r_dir_err;
`else
    assign dir_err = 1'b0;
`endif

endmodule

// File: tb/tb_pio_rw_sequencer.sv
// tb/tb_pio_rw_sequencer.sv - self-checking bench: directed table, corner sequences and random commands vs a PIO model
module tb_pio_rw_sequencer;

`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
    localparam int VFY_X = 2;
`else
    localparam int VFY_X = 0;
`endif
    localparam int TURN0 = 2;
    localparam int TURN1 = 0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, busy, dir_err;
    logic [1:0]  avm_cs, avm_wn;
    logic [31:0] cmd_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic [31:0] avm_wd    [2];
    logic [31:0] avm_rd    [2];
    logic [1:0]  avm_addr  [2];

    logic [31:0] pio_in    [2];
    logic [31:0] pio_dir   [2];
    logic        force_bad [2];

    int n_checks = 0;
    int n_fail   = 0;

    bit          mdl_out [2];
    bit          mdl_err [2];
    logic [34:0] exp_q[$];
    logic [34:0] acc_q0[$];
    logic [34:0] acc_q1[$];

    always #5 clk = ~clk;

    pio_rw_sequencer #(.TURN_CYCLES(TURN0), .DW(32)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0]), .dir_err(dir_err[0]),
        .avm_address(avm_addr[0]), .avm_chipselect(avm_cs[0]), .avm_write_n(avm_wn[0]),
        .avm_writedata(avm_wd[0]), .avm_readdata(avm_rd[0])
    );

    pio_rw_sequencer #(.TURN_CYCLES(TURN1), .DW(32)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1]), .dir_err(dir_err[1]),
        .avm_address(avm_addr[1]), .avm_chipselect(avm_cs[1]), .avm_write_n(avm_wn[1]),
        .avm_writedata(avm_wd[1]), .avm_readdata(avm_rd[1])
    );

    // PIO slave model: direction register plus registered readdata; data reads return the pin value.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                pio_dir[s] <= 32'h0;
                avm_rd[s]  <= 32'h0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (avm_cs[s] && !avm_wn[s] && avm_addr[s] == 2'd1) pio_dir[s] <= avm_wd[s];
                avm_rd[s] <= (avm_addr[s] == 2'd1) ? (force_bad[s] ? 32'hFFFF_FFFE : pio_dir[s]) : pio_in[s];
            end
        end
    end

    // Bus access log, entry = {is_write, address, writedata (0 for reads)}.
    always @(negedge clk) begin
        if (reset_n && avm_cs[0]) acc_q0.push_back({~avm_wn[0], avm_addr[0], avm_wn[0] ? 32'h0 : avm_wd[0]});
        if (reset_n && avm_cs[1]) acc_q1.push_back({~avm_wn[1], avm_addr[1], avm_wn[1] ? 32'h0 : avm_wd[1]});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_cmd(input int s, input bit wr, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd);
        int turn;
        turn = (s == 0) ? TURN0 : TURN1;
        exp_q.delete();
        lat = wr ? 2 : 3;
        if (wr) exp_q.push_back({1'b1, 2'd0, wd});
        if (mdl_out[s] != wr) begin
            exp_q.push_back({1'b1, 2'd1, wr ? 32'hFFFF_FFFF : 32'h0});
`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
            exp_q.push_back({1'b0, 2'd1, 32'h0});
            if (force_bad[s]) mdl_err[s] = 1'b1;
`endif
            mdl_out[s] = wr;
            lat = lat + 1 + turn + VFY_X;
        end
        if (!wr) exp_q.push_back({1'b0, 2'd0, 32'h0});
        rd = wr ? 32'h0 : pio_in[s];
    endtask

    task automatic check_accesses(input int s, input string nm, output int ndir);
        logic [34:0] got[$];
        got  = (s == 0) ? acc_q0 : acc_q1;
        ndir = 0;
        if (s == 0) acc_q0.delete(); else acc_q1.delete();
        chk($sformatf("%s n_access", nm), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s access%0d", nm, i), got[i], exp_q[i]);
        foreach (got[i]) if (got[i][34] && got[i][33:32] == 2'd1) ndir++;
    endtask

    task automatic run_cmd(input int s, input bit wr, input logic [31:0] wd, input int rdly,
                           output int lat, output logic [31:0] rd);
        int guard;
        @(negedge clk);
        cmd_valid[s] = 1'b1;
        cmd_write[s] = wr;
        cmd_wdata[s] = wd;
        guard = 0;
        while (!cmd_ready[s] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready[s]) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 cmd_valid[s] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[s] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata[s];
        for (int i = 0; i < rdly; i++) begin
            chk("hold rsp_valid", rsp_valid[s], 1'b1);
            chk("hold rsp_rdata", rsp_rdata[s], rd);
            chk("hold cmd_ready", cmd_ready[s], 1'b0);
            @(negedge clk);
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[s] = 1'b0;
        chk("post_rsp busy", busy[s], 1'b0);
        chk("post_rsp rsp_valid", rsp_valid[s], 1'b0);
    endtask

    task automatic do_cmd(input int s, input bit wr, input logic [31:0] wd, input logic [31:0] pin,
                          input int rdly, input string nm, output int lat, output logic [31:0] rd,
                          output int ndir);
        int          m_lat;
        logic [31:0] m_rd;
        pio_in[s] = pin;
        model_cmd(s, wr, wd, m_lat, m_rd);
        run_cmd(s, wr, wd, rdly, lat, rd);
        chk($sformatf("%s latency", nm), lat, m_lat);
        chk($sformatf("%s rdata", nm), rd, m_rd);
        check_accesses(s, nm, ndir);
        chk($sformatf("%s dir_err", nm), dir_err[s], mdl_err[s]);
    endtask

    task automatic check_reset_outputs(input string nm);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s cmd_ready%0d", nm, s), cmd_ready[s], 1'b0);
            chk($sformatf("%s rsp_valid%0d", nm, s), rsp_valid[s], 1'b0);
            chk($sformatf("%s rsp_rdata%0d", nm, s), rsp_rdata[s], 32'h0);
            chk($sformatf("%s busy%0d", nm, s), busy[s], 1'b0);
            chk($sformatf("%s dir_err%0d", nm, s), dir_err[s], 1'b0);
            chk($sformatf("%s avm%0d", nm, s), {avm_addr[s], avm_cs[s], avm_wn[s], avm_wd[s]},
                {2'd0, 1'b0, 1'b1, 32'h0});
        end
    endtask

    typedef struct {
        int          s;
        bit          wr;
        logic [31:0] wd;
        logic [31:0] pin;
        int          rdly;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          exp_ndir;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          lat;
        int          ndir;
        logic [31:0] rd;

        tbl[0] = '{s:0, wr:1'b0, wd:32'h0,         pin:32'hA5A5_0001, rdly:0, exp_lat:3,           exp_rd:32'hA5A5_0001, exp_ndir:0};
        tbl[1] = '{s:0, wr:1'b1, wd:32'hDEAD_BEEF, pin:32'h0,         rdly:0, exp_lat:5 + VFY_X,   exp_rd:32'h0,         exp_ndir:1};
        tbl[2] = '{s:0, wr:1'b1, wd:32'h1234_5678, pin:32'h0,         rdly:1, exp_lat:2,           exp_rd:32'h0,         exp_ndir:0};
        tbl[3] = '{s:0, wr:1'b0, wd:32'h0,         pin:32'h0000_00FF, rdly:5, exp_lat:6 + VFY_X,   exp_rd:32'h0000_00FF, exp_ndir:1};
        tbl[4] = '{s:0, wr:1'b0, wd:32'h0,         pin:32'h0F0F_0F0F, rdly:0, exp_lat:3,           exp_rd:32'h0F0F_0F0F, exp_ndir:0};
        tbl[5] = '{s:1, wr:1'b1, wd:32'hCAFE_F00D, pin:32'h0,         rdly:0, exp_lat:3 + VFY_X,   exp_rd:32'h0,         exp_ndir:1};
        tbl[6] = '{s:1, wr:1'b0, wd:32'h0,         pin:32'h0000_00FF, rdly:2, exp_lat:4 + VFY_X,   exp_rd:32'h0000_00FF, exp_ndir:1};
        tbl[7] = '{s:1, wr:1'b0, wd:32'h0,         pin:32'h0000_0001, rdly:0, exp_lat:3,           exp_rd:32'h0000_0001, exp_ndir:0};

        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cmd_valid[s] = 1'b0; cmd_write[s] = 1'b0; cmd_wdata[s] = 32'h0; rsp_ready[s] = 1'b0;
            pio_in[s] = 32'h0; force_bad[s] = 1'b0; mdl_out[s] = 1'b0; mdl_err[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            do_cmd(tbl[i].s, tbl[i].wr, tbl[i].wd, tbl[i].pin, tbl[i].rdly, $sformatf("tbl%0d", i), lat, rd, ndir);
            chk($sformatf("tbl%0d table latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d table rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d table dir_writes", i), ndir, tbl[i].exp_ndir);
        end

        // Reset during TURN on instance 0 (currently IN, write forces a direction change).
        @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_wdata[0] = 32'h55AA_55AA;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_turn busy", busy[0], 1'b1);
        chk("mid_turn cs", avm_cs[0], 1'b0);
        reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int s = 0; s < 2; s++) begin mdl_out[s] = 1'b0; mdl_err[s] = 1'b0; end
        acc_q0.delete();
        acc_q1.delete();
        repeat (2) @(negedge clk);
        do_cmd(0, 1'b0, 32'h0, 32'h3C3C_0000, 0, "after_reset_read", lat, rd, ndir);
        chk("after_reset_read dir_writes", ndir, 0);

        for (int i = 0; i < 30; i++) begin
            int s;
            s = int'($urandom_range(0, 1));
            do_cmd(s, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", i), lat, rd, ndir);
        end

`ifdef PIO_RW_SEQ_DIR_VERIFY_EN
        force_bad[0] = 1'b1;
        do_cmd(0, ~mdl_out[0], 32'h0BAD_0BAD, 32'h7777_0000, 0, "vfy_bad", lat, rd, ndir);
        chk("vfy_bad dir_err set", dir_err[0], 1'b1);
        force_bad[0] = 1'b0;
        do_cmd(0, ~mdl_out[0], 32'h0600_0D00, 32'h1111_2222, 0, "vfy_sticky", lat, rd, ndir);
        chk("vfy_sticky dir_err held", dir_err[0], 1'b1);
        chk("vfy other instance clean", dir_err[1], 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
